// File: rtl/matrix_result_reader_if.sv
// Bus bundle between matrix_result_reader and its neighbours: the four data-memory
// bank ports (addr/datain/write_en out, registered dataout in) and the tagged
// valid/ready result stream.
//   master: the reader (drives memory ports and the result stream)
//   slave : memory mux plus downstream consumer
interface matrix_result_reader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16
);
  logic [ADDR_W-1:0] mem_addr_a, mem_addr_b, mem_addr_c, mem_addr_d;
  logic [DATA_W-1:0] mem_datain_a, mem_datain_b, mem_datain_c, mem_datain_d;
  logic              mem_write_en_a, mem_write_en_b, mem_write_en_c, mem_write_en_d;
  logic [DATA_W-1:0] mem_dataout_a, mem_dataout_b, mem_dataout_c, mem_dataout_d;

  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_bank;
  logic [7:0]        out_index;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output mem_addr_a, mem_addr_b, mem_addr_c, mem_addr_d,
    output mem_datain_a, mem_datain_b, mem_datain_c, mem_datain_d,
    output mem_write_en_a, mem_write_en_b, mem_write_en_c, mem_write_en_d,
    input  mem_dataout_a, mem_dataout_b, mem_dataout_c, mem_dataout_d,
    output out_data, out_bank, out_index, out_valid,
    input  out_ready
  );

  modport slave (
    input  mem_addr_a, mem_addr_b, mem_addr_c, mem_addr_d,
    input  mem_datain_a, mem_datain_b, mem_datain_c, mem_datain_d,
    input  mem_write_en_a, mem_write_en_b, mem_write_en_c, mem_write_en_d,
    output mem_dataout_a, mem_dataout_b, mem_dataout_c, mem_dataout_d,
    input  out_data, out_bank, out_index, out_valid,
    output out_ready
  );
endinterface

// File: rtl/matrix_result_reader.sv
// Read-side master for the four-bank matrix data memory. On start it walks the result
// region (BASE_ADDR .. BASE_ADDR+ROW_LEN-1) of banks A..D in row-major order, emits each
// word on a tagged valid/ready stream and optionally zeroes the location afterwards.
//   clock, reset : clock, asynchronous active-high reset
//   start        : begin readout (only honoured while idle)
//   busy         : readout in progress, memory ports owned by this block
//   done         : one-cycle pulse in the final advance cycle
//   bus          : memory bank ports and result stream (master side)
// The interface instance must use the same DATA_W/ADDR_W as this module.
module matrix_result_reader #(
  parameter int unsigned DATA_W           = 16,
  parameter int unsigned ADDR_W           = 16,
  parameter int unsigned BASE_ADDR        = 24,
  parameter int unsigned ROW_LEN          = 4,
  parameter bit          CLEAR_AFTER_READ = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  matrix_result_reader_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StRead1,
    StRead2,
    StSend,
    StClear,
    StAdv
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        bank_q, bank_d;
  logic [7:0]        idx_q, idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_bank_q, out_bank_d;
  logic [7:0]        out_index_q, out_index_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic              last_idx;
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] addr;
  logic              clr_cycle;

  localparam logic [7:0] LastIdx = 8'(ROW_LEN - 1);

  assign last_idx  = (idx_q == LastIdx);
  // Address is derived from idx alone so it stays put across READ1/READ2/SEND/CLEAR.
  assign addr      = ADDR_W'(BASE_ADDR + 32'(idx_q));
  assign clr_cycle = (state_q == StClear);

  always_comb begin
    rd_data = '0;
    unique case (bank_q)
      2'd0: rd_data = bus.mem_dataout_a;
      2'd1: rd_data = bus.mem_dataout_b;
      2'd2: rd_data = bus.mem_dataout_c;
      2'd3: rd_data = bus.mem_dataout_d;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bank_d      = bank_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_bank_d  = out_bank_q;
    out_index_d = out_index_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          bank_d  = 2'd0;
          idx_d   = 8'd0;
          busy_d  = 1'b1;
          state_d = StRead1;
        end
      end
      // Address presented with write enable low; memory registers the read here.
      StRead1: state_d = StRead2;
      StRead2: begin
        out_data_d  = rd_data;
        out_bank_d  = bank_q;
        out_index_d = idx_q;
        out_valid_d = 1'b1;
        state_d     = StSend;
      end
      StSend: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = CLEAR_AFTER_READ ? StClear : StAdv;
        end
      end
      StClear: state_d = StAdv;
      StAdv: begin
        if (last_idx && (bank_q == 2'd3)) begin
          done    = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else if (last_idx) begin
          idx_d   = 8'd0;
          bank_d  = bank_q + 2'd1;
          state_d = StRead1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = StRead1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      bank_q      <= 2'd0;
      idx_q       <= 8'd0;
      out_data_q  <= '0;
      out_bank_q  <= 2'd0;
      out_index_q <= 8'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bank_q      <= bank_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_bank_q  <= out_bank_d;
      out_index_q <= out_index_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign busy = busy_q;

  assign bus.mem_addr_a = addr;
  assign bus.mem_addr_b = addr;
  assign bus.mem_addr_c = addr;
  assign bus.mem_addr_d = addr;

  assign bus.mem_datain_a = '0;
  assign bus.mem_datain_b = '0;
  assign bus.mem_datain_c = '0;
  assign bus.mem_datain_d = '0;

  // Decoded from state so reset drops the enable without waiting for a clock.
  assign bus.mem_write_en_a = clr_cycle && (bank_q == 2'd0);
  assign bus.mem_write_en_b = clr_cycle && (bank_q == 2'd1);
  assign bus.mem_write_en_c = clr_cycle && (bank_q == 2'd2);
  assign bus.mem_write_en_d = clr_cycle && (bank_q == 2'd3);

  assign bus.out_data  = out_data_q;
  assign bus.out_bank  = out_bank_q;
  assign bus.out_index = out_index_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_result_reader.sv
// Bench for matrix_result_reader. Three instances: 0 = defaults, 1 = clear-after-read,
// 2 = ROW_LEN 1 at BASE_ADDR 40. A behavioural four-bank memory sits behind each.
module tb_matrix_result_reader;
  localparam int NumDut = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;

  logic        start   [NumDut];
  logic        ready   [NumDut];
  logic        busy_w  [NumDut];
  logic        done_w  [NumDut];
  logic        valid_w [NumDut];
  logic [15:0] data_w  [NumDut];
  logic [1:0]  bank_w  [NumDut];
  logic [7:0]  idx_w   [NumDut];
  logic [3:0]  we_w    [NumDut];
  logic [15:0] addr_w  [NumDut][4];
  logic [15:0] din_w   [NumDut][4];
  logic [15:0] dout_r  [NumDut][4];
  logic [15:0] mem     [NumDut][4][64];
  logic [15:0] ref_data[NumDut][4][64];

  logic        pre_we;
  int          pre_n, pre_b;
  logic [5:0]  pre_a;
  logic [15:0] pre_d;

  int checks = 0;
  int errors = 0;

  logic [25:0] got_q[$];
  logic [25:0] exp_q[$];
  logic [17:0] wev_q[$];
  int first_valid_at, done_at, done_cnt, unstable_cnt, multi_we_cnt;
  bit timed_out;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int base_of(input int n);
    return (n == 2) ? 40 : 24;
  endfunction

  function automatic int rows_of(input int n);
    return (n == 2) ? 1 : 4;
  endfunction

  matrix_result_reader_if bus [NumDut] ();

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    matrix_result_reader #(
      .DATA_W          (16),
      .ADDR_W          (16),
      .BASE_ADDR       ((g == 2) ? 40 : 24),
      .ROW_LEN         ((g == 2) ? 1 : 4),
      .CLEAR_AFTER_READ(g == 1)
    ) dut (
      .clock(clk),
      .reset(rst),
      .start(start[g]),
      .busy (busy_w[g]),
      .done (done_w[g]),
      .bus  (bus[g])
    );
    assign bus[g].out_ready     = ready[g];
    assign valid_w[g]           = bus[g].out_valid;
    assign data_w[g]            = bus[g].out_data;
    assign bank_w[g]            = bus[g].out_bank;
    assign idx_w[g]             = bus[g].out_index;
    assign we_w[g]              = {bus[g].mem_write_en_d, bus[g].mem_write_en_c,
                                   bus[g].mem_write_en_b, bus[g].mem_write_en_a};
    assign addr_w[g][0]         = bus[g].mem_addr_a;
    assign addr_w[g][1]         = bus[g].mem_addr_b;
    assign addr_w[g][2]         = bus[g].mem_addr_c;
    assign addr_w[g][3]         = bus[g].mem_addr_d;
    assign din_w[g][0]          = bus[g].mem_datain_a;
    assign din_w[g][1]          = bus[g].mem_datain_b;
    assign din_w[g][2]          = bus[g].mem_datain_c;
    assign din_w[g][3]          = bus[g].mem_datain_d;
    assign bus[g].mem_dataout_a = dout_r[g][0];
    assign bus[g].mem_dataout_b = dout_r[g][1];
    assign bus[g].mem_dataout_c = dout_r[g][2];
    assign bus[g].mem_dataout_d = dout_r[g][3];
  end

  // Memory banks: registered read, write on enable, plus a bench preload port.
  always @(posedge clk) begin
    for (int n = 0; n < NumDut; n++) begin
      for (int b = 0; b < 4; b++) begin
        if (pre_we && pre_n == n && pre_b == b) mem[n][b][pre_a] <= pre_d;
        else if (we_w[n][b]) mem[n][b][addr_w[n][b][5:0]] <= din_w[n][b];
        dout_r[n][b] <= mem[n][b][addr_w[n][b][5:0]];
      end
    end
  end

  task automatic preload(input int n, input bit rnd);
    logic [15:0] v;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < rows_of(n); i++) begin
        v = rnd ? 16'($urandom) : 16'(k * 16 + i);
        ref_data[n][k][i] = v;
        @(posedge clk); #1;
        pre_we = 1'b1; pre_n = n; pre_b = k; pre_a = 6'(base_of(n) + i); pre_d = v;
      end
    end
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Reference model: every bank in order, every index in order, data as preloaded.
  task automatic build_expected(input int n);
    exp_q.delete();
    for (int k = 0; k < 4; k++)
      for (int i = 0; i < rows_of(n); i++)
        exp_q.push_back({2'(k), 8'(i), ref_data[n][k][i]});
  endtask

  // Runs one readout on instance n, recording handshakes, write pulses and timing.
  task automatic collect(input int n, input int ready_pct, input bit extra_start,
                         input int budget);
    int unsigned base;
    int rel, tail;
    bit pv, pr;
    logic [25:0] pw, cur;
    got_q.delete(); wev_q.delete();
    first_valid_at = -1; done_at = -1; done_cnt = 0; unstable_cnt = 0; multi_we_cnt = 0;
    timed_out = 1'b0; pv = 1'b0; pr = 1'b0; pw = '0; tail = -1;
    @(posedge clk); #1;
    base = cyc;
    start[n] = 1'b1;
    ready[n] = ($urandom_range(99) < ready_pct);
    for (int t = 0; t < budget; t++) begin
      @(negedge clk);
      rel = int'(cyc - base);
      cur = {bank_w[n], idx_w[n], data_w[n]};
      if (pv && !pr && (!valid_w[n] || cur !== pw)) unstable_cnt++;
      if (valid_w[n] && first_valid_at < 0) first_valid_at = rel;
      if (valid_w[n] && ready[n]) got_q.push_back(cur);
      if ($countones(we_w[n]) > 1) multi_we_cnt++;
      for (int b = 0; b < 4; b++)
        if (we_w[n][b]) wev_q.push_back({2'(b), addr_w[n][b]});
      if (done_w[n]) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = rel;
          tail = t + 8;
        end
      end
      pv = valid_w[n]; pr = ready[n]; pw = cur;
      if (t == tail) break;
      @(posedge clk); #1;
      start[n] = extra_start && (rel + 1 == 5 || rel + 1 == 20);
      ready[n] = ($urandom_range(99) < ready_pct);
    end
    start[n] = 1'b0;
    ready[n] = 1'b0;
    if (done_at < 0) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    for (int n = 0; n < NumDut; n++) begin
      checks++;
      if ({valid_w[n], busy_w[n], done_w[n], we_w[n]} !== 7'b0) begin
        errors++;
        $display("FAIL reset_ctl[%0d] got v%b b%b d%b we%b want all 0", n, valid_w[n],
                 busy_w[n], done_w[n], we_w[n]);
      end
      checks++;
      if ({bank_w[n], idx_w[n], data_w[n]} !== 26'd0) begin
        errors++;
        $display("FAIL reset_out[%0d] got %h/%h/%h want 0/0/0", n, bank_w[n], idx_w[n],
                 data_w[n]);
      end
      checks++;
      if (addr_w[n][0] !== 16'(base_of(n)) || addr_w[n][3] !== 16'(base_of(n))) begin
        errors++;
        $display("FAIL reset_addr[%0d] got %h/%h want %h", n, addr_w[n][0], addr_w[n][3],
                 base_of(n));
      end
    end
  endtask

  task automatic test_basic();
    preload(0, 1'b0);
    build_expected(0);
    collect(0, 100, 1'b0, 300);
    checks++;
    if (timed_out) begin errors++; $display("FAIL basic_timeout got no done want done"); end
    checks++;
    if (got_q.size() != 16) begin
      errors++; $display("FAIL basic_count got %0d want 16", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL basic_word%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (first_valid_at != 3) begin
      errors++; $display("FAIL basic_latency got %0d want 3", first_valid_at);
    end
    checks++;
    if (done_at != 64 || done_cnt != 1) begin
      errors++; $display("FAIL basic_done got at %0d x%0d want at 64 x1", done_at, done_cnt);
    end
    checks++;
    if (wev_q.size() != 0) begin
      errors++; $display("FAIL basic_no_write got %0d pulses want 0", wev_q.size());
    end
  endtask

  task automatic test_backpressure();
    preload(0, 1'b1);
    build_expected(0);
    collect(0, 30, 1'b0, 2000);
    checks++;
    if (timed_out) begin errors++; $display("FAIL bp_timeout got no done want done"); end
    checks++;
    if (got_q.size() != 16) begin
      errors++; $display("FAIL bp_count got %0d want 16", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_word%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (unstable_cnt != 0) begin
      errors++; $display("FAIL bp_stable got %0d changes want 0", unstable_cnt);
    end
    checks++;
    if (done_cnt != 1) begin
      errors++; $display("FAIL bp_done got %0d pulses want 1", done_cnt);
    end
  endtask

  task automatic test_clear();
    preload(1, 1'b1);
    build_expected(1);
    collect(1, 100, 1'b0, 300);
    checks++;
    if (timed_out) begin errors++; $display("FAIL clr_timeout got no done want done"); end
    checks++;
    if (got_q.size() != 16 || wev_q.size() != 16) begin
      errors++;
      $display("FAIL clr_count got %0d words %0d writes want 16 16", got_q.size(), wev_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL clr_word%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    for (int i = 0; i < exp_q.size() && i < wev_q.size(); i++) begin
      checks++;
      if (wev_q[i] !== {exp_q[i][25:24], 16'(24 + int'(exp_q[i][23:16]))}) begin
        errors++; $display("FAIL clr_write%0d got %h want bank/addr of word %h", i, wev_q[i],
                           exp_q[i]);
      end
    end
    checks++;
    if (multi_we_cnt != 0) begin
      errors++; $display("FAIL clr_onehot got %0d multi-enable cycles want 0", multi_we_cnt);
    end
    checks++;
    if (done_at != 80) begin errors++; $display("FAIL clr_done got %0d want 80", done_at); end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (mem[1][k][24 + i] !== 16'h0) begin
          errors++; $display("FAIL clr_zero b%0d i%0d got %h want 0", k, i, mem[1][k][24 + i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    preload(0, 1'b1);
    build_expected(0);
    collect(0, 100, 1'b1, 300);
    checks++;
    if (got_q.size() != 16) begin
      errors++; $display("FAIL swb_count got %0d want 16", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL swb_word%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_cnt != 1 || done_at != 64) begin
      errors++; $display("FAIL swb_done got at %0d x%0d want at 64 x1", done_at, done_cnt);
    end
  endtask

  task automatic test_reset_mid_run();
    bit found;
    preload(0, 1'b1);
    build_expected(0);
    found = 1'b0;
    @(posedge clk); #1;
    start[0] = 1'b1; ready[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    for (int t = 0; t < 200 && !found; t++) begin
      @(negedge clk);
      if (valid_w[0] && bank_w[0] == 2'd1 && idx_w[0] == 8'd2) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL rmr_reach got no B[2] want B[2] in SEND"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({valid_w[0], busy_w[0], done_w[0], we_w[0]} !== 7'b0) begin
      errors++; $display("FAIL rmr_ctl got v%b b%b d%b we%b want all 0", valid_w[0], busy_w[0],
                         done_w[0], we_w[0]);
    end
    checks++;
    if ({bank_w[0], idx_w[0], data_w[0]} !== 26'd0 || addr_w[0][0] !== 16'd24) begin
      errors++; $display("FAIL rmr_out got %h/%h/%h addr %h want 0/0/0 addr 18", bank_w[0],
                         idx_w[0], data_w[0], addr_w[0][0]);
    end
    ready[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    collect(0, 100, 1'b0, 300);
    checks++;
    if (got_q.size() != 16) begin
      errors++; $display("FAIL rmr_count got %0d want 16", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rmr_word%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_rowlen1();
    preload(2, 1'b1);
    build_expected(2);
    collect(2, 100, 1'b0, 200);
    checks++;
    if (got_q.size() != 4) begin
      errors++; $display("FAIL r1_count got %0d want 4", got_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL r1_word%0d got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (done_at != 16 || first_valid_at != 3) begin
      errors++; $display("FAIL r1_timing got first %0d done %0d want 3 16", first_valid_at,
                         done_at);
    end
  endtask

  initial begin
    for (int n = 0; n < NumDut; n++) begin
      start[n] = 1'b0;
      ready[n] = 1'b0;
    end
    pre_we = 1'b0; pre_n = 0; pre_b = 0; pre_a = '0; pre_d = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    test_basic();
    test_backpressure();
    test_clear();
    test_start_while_busy();
    test_reset_mid_run();
    test_rowlen1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
